// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : branch_pkg
//  Description : Shared constants for the branch-resolution stage: branch
//                opcode encodings, opcode width and FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package branch_pkg;

    // Width of the branch opcode field
    localparam int unsigned c_op_width = 3;

    // Branch opcodes (unsigned conditions on the latched compare flags)
    localparam logic [c_op_width-1:0] c_op_none = 3'b000;
    localparam logic [c_op_width-1:0] c_op_jmp  = 3'b001;
    localparam logic [c_op_width-1:0] c_op_je   = 3'b010;
    localparam logic [c_op_width-1:0] c_op_jne  = 3'b011;
    localparam logic [c_op_width-1:0] c_op_ja   = 3'b100;
    localparam logic [c_op_width-1:0] c_op_jb   = 3'b101;
    localparam logic [c_op_width-1:0] c_op_jae  = 3'b110;
    localparam logic [c_op_width-1:0] c_op_jbe  = 3'b111;

    // FSM state encoding
    localparam int unsigned c_state_width = 2;

    localparam logic [c_state_width-1:0] c_st_run   = 2'd0;
    localparam logic [c_state_width-1:0] c_st_flush = 2'd1;
    localparam logic [c_state_width-1:0] c_st_halt  = 2'd2;

endpackage : branch_pkg
`default_nettype wire

// File: rtl/branch_cond_eval.sv
`default_nettype none
// ============================================================================
//  Module      : branch_cond_eval
//  Description : Purely combinational branch-condition evaluator. Decides
//                whether an opcode's condition holds for the given zero
//                and carry flags (carry = first operand below second).
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_cond_eval
    import branch_pkg::*;
(
    input  logic [c_op_width-1:0] br_op,
    input  logic                  z,
    input  logic                  c,
    output logic                  cond_true
);

    // Map each opcode onto its flag condition; "none" never branches
    always_comb begin
        cond_true = 1'b0;
        case (br_op)
            c_op_none: cond_true = 1'b0;
            c_op_jmp:  cond_true = 1'b1;
            c_op_je:   cond_true = z;
            c_op_jne:  cond_true = ~z;
            c_op_ja:   cond_true = ~z & ~c;
            c_op_jb:   cond_true = c;
            c_op_jae:  cond_true = ~c;
            c_op_jbe:  cond_true = z | c;
            default:   cond_true = 1'b0;
        endcase
    end

endmodule : branch_cond_eval
`default_nettype wire

// File: rtl/branch_control.sv
`default_nettype none
// ============================================================================
//  Module      : branch_control
//  Description : Program counter and branch resolution. Holds the compare
//                flag register, evaluates conditional jumps against the
//                (forwarded) flags, and steers the fetch address. A taken
//                branch costs one wrong-path bubble (FLUSH); a jump to its
//                own address parks the core in HALT until reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_control
    import branch_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 10,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flags_we,
    input  logic                  zero_flag,
    input  logic                  carry_flag,
    input  logic                  instr_valid,
    input  logic [c_op_width-1:0] br_op,
    input  logic [ADDR_WIDTH-1:0] br_target,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  z_reg,
    output logic                  c_reg,
    output logic                  branch_taken,
    output logic                  flush,
    output logic                  halted
);

    localparam logic [ADDR_WIDTH-1:0] c_pc_one = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    // Registered state
    logic [c_state_width-1:0] r_state;
    logic [ADDR_WIDTH-1:0]    r_pc;
    logic                     r_z;
    logic                     r_c;
    logic                     r_taken;

    // Next-state values
    logic [c_state_width-1:0] w_state_nxt;
    logic [ADDR_WIDTH-1:0]    w_pc_nxt;
    logic                     w_z_nxt;
    logic                     w_c_nxt;
    logic                     w_taken_nxt;

    // Decision helpers
    logic                     w_eff_z;
    logic                     w_eff_c;
    logic                     w_cond_true;
    logic                     w_accept;
    logic                     w_take;
    logic                     w_self_loop;
    logic [ADDR_WIDTH-1:0]    w_pc_inc;

    // A compare in the same cycle feeds its flags straight to the branch
    // evaluation so compare-and-branch needs no extra cycle.
    assign w_eff_z = flags_we ? zero_flag  : r_z;
    assign w_eff_c = flags_we ? carry_flag : r_c;

    branch_cond_eval u_cond_eval (
        .br_op     (br_op),
        .z         (w_eff_z),
        .c         (w_eff_c),
        .cond_true (w_cond_true)
    );

    assign w_accept    = instr_valid & ~stall & (r_state == c_st_run);
    assign w_take      = w_accept & w_cond_true;
    assign w_self_loop = (br_target == r_pc);
    assign w_pc_inc    = r_pc + c_pc_one;

    // Next-state and next-output decode; stall freezes everything and
    // suppresses the taken pulse.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_z_nxt     = r_z;
        w_c_nxt     = r_c;
        w_taken_nxt = 1'b0;
        if (!stall) begin
            case (r_state)
                c_st_run: begin
                    if (flags_we) begin
                        w_z_nxt = zero_flag;
                        w_c_nxt = carry_flag;
                    end
                    if (w_take) begin
                        w_taken_nxt = 1'b1;
                        if (w_self_loop) begin
                            // Jump to itself: nothing further can execute
                            w_state_nxt = c_st_halt;
                        end else begin
                            w_pc_nxt    = br_target;
                            w_state_nxt = c_st_flush;
                        end
                    end else begin
                        w_pc_nxt = w_pc_inc;
                    end
                end
                c_st_flush: begin
                    // Decode slot holds the wrong-path instruction: drop it,
                    // including any compare it carries, and keep fetching.
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = c_st_run;
                end
                c_st_halt: begin
                    w_state_nxt = c_st_halt;
                end
                default: begin
                    // Unused encoding: recover into normal execution
                    w_state_nxt = c_st_run;
                end
            endcase
        end
    end

    // State, PC, flag and pulse registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_run;
            r_pc    <= RESET_PC;
            r_z     <= 1'b0;
            r_c     <= 1'b0;
            r_taken <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_z     <= w_z_nxt;
            r_c     <= w_c_nxt;
            r_taken <= w_taken_nxt;
        end
    end

    assign pc           = r_pc;
    assign z_reg        = r_z;
    assign c_reg        = r_c;
    assign branch_taken = r_taken;
    assign flush        = (r_state == c_st_flush);
    assign halted       = (r_state == c_st_halt);

endmodule : branch_control
`default_nettype wire

// File: tb/tb_branch_control.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_branch_control
//  Description : Self-checking bench for branch_control: directed vector
//                table, hand-written reset/halt/wrap sequences, and a
//                randomized run against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_control;

    localparam int AW = 10;

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_JE   = 3'b010;
    localparam logic [2:0] OP_JNE  = 3'b011;
    localparam logic [2:0] OP_JA   = 3'b100;
    localparam logic [2:0] OP_JB   = 3'b101;
    localparam logic [2:0] OP_JBE  = 3'b111;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall = 1'b0;
    logic          flags_we = 1'b0;
    logic          zero_flag = 1'b0;
    logic          carry_flag = 1'b0;
    logic          instr_valid = 1'b0;
    logic [2:0]    br_op = 3'b000;
    logic [AW-1:0] br_target = '0;
    logic [AW-1:0] pc;
    logic          z_reg;
    logic          c_reg;
    logic          branch_taken;
    logic          flush;
    logic          halted;

    int n_checks = 0;
    int n_fail   = 0;

    branch_control #(
        .ADDR_WIDTH (AW),
        .RESET_PC   ('0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .flags_we     (flags_we),
        .zero_flag    (zero_flag),
        .carry_flag   (carry_flag),
        .instr_valid  (instr_valid),
        .br_op        (br_op),
        .br_target    (br_target),
        .pc           (pc),
        .z_reg        (z_reg),
        .c_reg        (c_reg),
        .branch_taken (branch_taken),
        .flush        (flush),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    // ctl = {stall, flags_we, zero_flag, carry_flag, instr_valid}
    // eflg = {z_reg, c_reg, branch_taken, flush, halted}
    typedef struct {
        logic [4:0]    ctl;
        logic [2:0]    op;
        logic [AW-1:0] tgt;
        logic [AW-1:0] epc;
        logic [4:0]    eflg;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model state
    int m_pc;
    bit m_z, m_c, m_tk, m_fl, m_ht;

    task automatic add(input logic [4:0] ctl, input logic [2:0] op,
                       input logic [AW-1:0] tgt, input logic [AW-1:0] epc,
                       input logic [4:0] eflg);
        vec_t t;
        t.ctl = ctl; t.op = op; t.tgt = tgt; t.epc = epc; t.eflg = eflg;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic [4:0] ctl, input logic [2:0] op, input logic [AW-1:0] tgt);
        {stall, flags_we, zero_flag, carry_flag, instr_valid} = ctl;
        br_op     = op;
        br_target = tgt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [AW-1:0] epc, input logic [4:0] eflg);
        logic [4:0] act;
        act = {z_reg, c_reg, branch_taken, flush, halted};
        n_checks++;
        if (pc !== epc || act !== eflg) begin
            n_fail++;
            $display("FAIL %s: got pc=%h z/c/tk/fl/ht=%b, want pc=%h z/c/tk/fl/ht=%b",
                     name, pc, act, epc, eflg);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_z = 0; m_c = 0; m_tk = 0; m_fl = 0; m_ht = 0;
    endtask

    // One clock of architectural behaviour, from the current input values
    task automatic model_step();
        bit z, c;
        bit cond[8];
        m_tk = 0;
        if (stall || m_ht) return;
        if (m_fl) begin
            m_pc = (m_pc + 1) % (1 << AW);
            m_fl = 0;
            return;
        end
        z = flags_we ? zero_flag : m_z;
        c = flags_we ? carry_flag : m_c;
        cond = '{1'b0, 1'b1, z, !z, !z && !c, c, !c, z || c};
        if (flags_we) begin
            m_z = zero_flag;
            m_c = carry_flag;
        end
        if (instr_valid && cond[br_op]) begin
            m_tk = 1;
            if (int'(br_target) == m_pc) m_ht = 1;
            else begin
                m_pc = int'(br_target);
                m_fl = 1;
            end
        end else begin
            m_pc = (m_pc + 1) % (1 << AW);
        end
    endtask

    initial begin
        int halt_cnt;

        // ---------------- reset state ----------------
        #12;
        check("reset_values", 10'h000, 5'b00000);
        rst_n = 1'b1;

        // ---------------- directed table ----------------
        add(5'b00000, OP_NONE, 10'h000, 10'h001, 5'b00000);
        add(5'b00000, OP_NONE, 10'h000, 10'h002, 5'b00000);
        add(5'b00000, OP_NONE, 10'h000, 10'h003, 5'b00000);
        add(5'b01011, OP_JB,   10'h040, 10'h040, 5'b01110); // fwd compare + JB
        add(5'b00000, OP_NONE, 10'h000, 10'h041, 5'b01000);
        add(5'b01100, OP_NONE, 10'h000, 10'h042, 5'b10000); // latch Z=1,C=0
        add(5'b00001, OP_JNE,  10'h080, 10'h043, 5'b10000);
        add(5'b00001, OP_JA,   10'h080, 10'h044, 5'b10000);
        add(5'b00001, OP_JBE,  10'h080, 10'h080, 5'b10110);
        add(5'b00000, OP_NONE, 10'h000, 10'h081, 5'b10000);
        add(5'b00001, OP_JMP,  10'h010, 10'h010, 5'b10110);
        add(5'b01011, OP_JMP,  10'h020, 10'h011, 5'b10000); // wrong path ignored
        add(5'b00000, OP_NONE, 10'h000, 10'h012, 5'b10000);
        add(5'b10001, OP_JMP,  10'h030, 10'h012, 5'b10000); // stall holds JMP
        add(5'b11011, OP_JMP,  10'h030, 10'h012, 5'b10000); // stalled compare
        add(5'b10001, OP_JMP,  10'h030, 10'h012, 5'b10000);
        add(5'b00001, OP_JMP,  10'h030, 10'h030, 5'b10110);
        add(5'b10000, OP_NONE, 10'h000, 10'h030, 5'b10010); // stall in FLUSH
        add(5'b00000, OP_NONE, 10'h000, 10'h031, 5'b10000);
        add(5'b00001, OP_JE,   10'h005, 10'h005, 5'b10110);
        add(5'b00000, OP_NONE, 10'h000, 10'h006, 5'b10000);
        add(5'b00000, OP_NONE, 10'h000, 10'h007, 5'b10000);
        add(5'b00001, OP_JMP,  10'h007, 10'h007, 5'b10101); // self-loop halt

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].ctl, vecs[i].op, vecs[i].tgt);
            tick();
            check($sformatf("vec%0d", i), vecs[i].epc, vecs[i].eflg);
        end

        // ---------------- halt holds under any input ----------------
        for (int i = 0; i < 10; i++) begin
            drive(5'($urandom_range(0, 31)) & 5'b01111, 3'($urandom_range(0, 7)),
                  10'($urandom_range(0, 1023)));
            tick();
            check($sformatf("halt_hold%0d", i), 10'h007, 5'b10001);
        end

        // async reset out of HALT, mid-cycle
        drive(5'b00000, OP_NONE, 10'h000);
        #2 rst_n = 1'b0;
        #1 check("halt_async_reset", 10'h000, 5'b00000);
        #2 rst_n = 1'b1;

        // ---------------- PC wrap ----------------
        drive(5'b00001, OP_JMP, 10'h3FE);
        tick();
        check("wrap_jmp", 10'h3FE, 5'b00110);
        drive(5'b00000, OP_NONE, 10'h000);
        tick();
        check("wrap_3ff", 10'h3FF, 5'b00000);
        tick();
        check("wrap_000", 10'h000, 5'b00000);

        // ---------------- async reset mid-FLUSH ----------------
        drive(5'b00001, OP_JMP, 10'h100);
        tick();
        check("flush_pre_reset", 10'h100, 5'b00110);
        drive(5'b00000, OP_NONE, 10'h000);
        #2 rst_n = 1'b0;
        #1 check("flush_async_reset", 10'h000, 5'b00000);
        #2 rst_n = 1'b1;
        tick();
        check("post_flush_reset", 10'h001, 5'b00000);

        // ---------------- randomized vs model ----------------
        drive(5'b00000, OP_NONE, 10'h000);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check("rand_start_reset", m_pc[AW-1:0], {m_z, m_c, m_tk, m_fl, m_ht});
        #2 rst_n = 1'b1;
        halt_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            if (m_ht && halt_cnt >= 4) begin
                halt_cnt = 0;
                rst_n = 1'b0;
                model_reset();
                #1 check("rand_reset", m_pc[AW-1:0], {m_z, m_c, m_tk, m_fl, m_ht});
                #2 rst_n = 1'b1;
            end
            stall       = ($urandom_range(0, 4) == 0);
            flags_we    = ($urandom_range(0, 2) == 0);
            zero_flag   = 1'($urandom_range(0, 1));
            carry_flag  = 1'($urandom_range(0, 1));
            instr_valid = ($urandom_range(0, 9) < 7);
            br_op       = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 39) == 0) br_target = m_pc[AW-1:0];
            else br_target = 10'($urandom_range(0, 1023));
            model_step();
            tick();
            if (m_ht) halt_cnt++;
            check($sformatf("rand%0d", i), m_pc[AW-1:0], {m_z, m_c, m_tk, m_fl, m_ht});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_branch_control
`default_nettype wire
